// File: rtl/pmips_pkg.sv
// Shared PMIPS issue-control definitions: opcodes, ALUOp codes, control bundle, FSM states.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package pmips_pkg;

  // Opcode values, kept 32 bits wide so any opcode width can be zero-extended into the compare.
  localparam logic [31:0] OP_RTYPE = 32'd0;
  localparam logic [31:0] OP_BEQ   = 32'd2;
  localparam logic [31:0] OP_ADDI  = 32'd3;
  localparam logic [31:0] OP_LW    = 32'd5;
  localparam logic [31:0] OP_SW    = 32'd6;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  // Datapath control lines driven into ID/EX.
  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    branch;
    logic    mem_write;
    logic    mem_read;
    logic    mem_to_reg;
    alu_op_t alu_op;
  } ctrl_t;

  // Decode result: known opcode, whether rt is read as a source, and the controls.
  // rs is a source for every known opcode; the destination is rd when reg_dst=1, else rt.
  typedef struct packed {
    logic  known;
    logic  src_rt;
    ctrl_t ctrl;
  } dec_t;

  typedef enum logic [1:0] {
    RESET_BUB = 2'd0,
    ISSUE     = 2'd1,
    STALL     = 2'd2
  } state_t;

  function automatic dec_t decode_op(input logic [31:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.known          = 1'b1;
        d.src_rt         = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.reg_dst   = 1'b1;
        d.ctrl.alu_op    = ALU_FUNCT;
      end
      OP_BEQ: begin
        d.known       = 1'b1;
        d.src_rt      = 1'b1;
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        d.known          = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        d.known           = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        d.known          = 1'b1;
        d.src_rt         = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pmips_scoreboard.sv
// In-flight destination scoreboard with RAW hazard compare against the IF/ID source fields.
// Latency: shift register advances every cycle; hazard is combinational from entries + sources.
// Backpressure: none; the caller turns hazard into a bubble.
// Ports: clock, reset (sync, active-high), load/dest (entry 0 input), rs/rt + chk_rs/chk_rt
//        (sources to check and whether each is really read), hazard (out).
module pmips_scoreboard
#(
  parameter int DEPTH     = 3,
  parameter int REGW      = 3,
  parameter int WB_BYPASS = 1
)
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [REGW-1:0] dest,
  input  logic [REGW-1:0] rs,
  input  logic [REGW-1:0] rt,
  input  logic            chk_rs,
  input  logic            chk_rt,
  output logic            hazard
);

  // With write-before-read in the register file the oldest entry is already visible to the reader.
  localparam int NCHK = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  generate
    if (DEPTH > 0) begin : g_sb
      logic [DEPTH-1:0]           vld_q;
      logic [DEPTH-1:0][REGW-1:0] dst_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          vld_q <= '0;
          dst_q <= '0;
        end else begin
          vld_q[0] <= load;
          dst_q[0] <= dest;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dst_q[i] <= dst_q[i-1];
          end
        end
      end

      // Register 0 is hard-wired, so a pending write to it never blocks a reader.
      always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NCHK; i++) begin
          if (vld_q[i] && (dst_q[i] != '0) &&
              ((chk_rs && (rs == dst_q[i])) || (chk_rt && (rt == dst_q[i])))) begin
            hazard = 1'b1;
          end
        end
      end
    end else begin : g_empty
      logic unused_in;
      assign unused_in = ^{clock, reset, load, dest, rs, rt, chk_rs, chk_rt};
      assign hazard    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pmips_issue_ctrl.sv
// PMIPS issue controller: decodes IF/ID opcode, drives ID/EX controls, inserts bubbles.
// Latency: controls are combinational in the issue cycle; fixed/branch stalls follow the issue.
// Backpressure: pc_stall=1 holds PC and IF/ID on every bubble (reset, stall, hazard).
// Ports: clock, reset (sync, active-high), opcode/rs/rt/rd from IF/ID, pc_stall, issue,
//        datapath controls + alu_op, stall_cycles (saturating bubble count).
module pmips_issue_ctrl
  import pmips_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int REGW        = 3,
  parameter int HAZARD_MODE = 0,
  parameter int DEPTH       = 3,
  parameter int BR_STALL    = 3,
  parameter int WB_BYPASS   = 1,
  parameter int CNTW        = 16
)
(
  input  logic            clock,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] rs,
  input  logic [REGW-1:0] rt,
  input  logic [REGW-1:0] rd,
  output logic            pc_stall,
  output logic            issue,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            branch,
  output logic            mem_write,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic [1:0]      alu_op,
  output logic [CNTW-1:0] stall_cycles
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] stall_q;
  dec_t            dec;
  ctrl_t           ctrl;
  logic            hazard;
  logic            bubble_cnt;
  logic [REGW-1:0] dest;

  assign dec  = decode_op(32'(opcode));
  assign dest = dec.ctrl.reg_dst ? rd : rt;

  generate
    if (HAZARD_MODE == 1) begin : g_sb
      // Unknown opcodes read nothing, so they can never be held by the scoreboard.
      pmips_scoreboard #(
        .DEPTH    (DEPTH),
        .REGW     (REGW),
        .WB_BYPASS(WB_BYPASS)
      ) u_sb (
        .clock  (clock),
        .reset  (reset),
        .load   (issue & ctrl.reg_write),
        .dest   (dest),
        .rs     (rs),
        .rt     (rt),
        .chk_rs (dec.known),
        .chk_rt (dec.src_rt),
        .hazard (hazard)
      );
    end else begin : g_nosb
      logic unused_sb;
      assign unused_sb = ^{rs, dest, dec.src_rt};
      assign hazard    = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl       = '0;
    pc_stall   = 1'b1;
    issue      = 1'b0;
    bubble_cnt = 1'b0;
    case (state_q)
      // Single uncounted bubble after reset release.
      RESET_BUB: state_d = ISSUE;
      ISSUE: begin
        if (hazard) begin
          // Hazard beats a beq in the same slot; the beq stalls once it actually issues.
          bubble_cnt = 1'b1;
        end else begin
          pc_stall = 1'b0;
          issue    = 1'b1;
          ctrl     = dec.ctrl;
          if (dec.known) begin
            if (HAZARD_MODE == 0) begin
              if (DEPTH > 0) begin
                cnt_d   = CNTW'(DEPTH);
                state_d = STALL;
              end
            end else if (dec.ctrl.branch && (BR_STALL > 0)) begin
              cnt_d   = CNTW'(BR_STALL);
              state_d = STALL;
            end
          end
        end
      end
      STALL: begin
        bubble_cnt = 1'b1;
        cnt_d      = cnt_q - CNTW'(1);
        if (cnt_q <= CNTW'(1)) begin
          state_d = ISSUE;
        end
      end
      default: state_d = RESET_BUB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_BUB;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bubble_cnt && (stall_q != '1)) begin
        stall_q <= stall_q + CNTW'(1);
      end
    end
  end

  assign reg_write    = ctrl.reg_write;
  assign reg_dst      = ctrl.reg_dst;
  assign alu_src      = ctrl.alu_src;
  assign branch       = ctrl.branch;
  assign mem_write    = ctrl.mem_write;
  assign mem_read     = ctrl.mem_read;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign alu_op       = ctrl.alu_op;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pmips_issue_ctrl.sv
// Directed bench for pmips_issue_ctrl: fixed-stall, interlock and narrow-counter instances share inputs.
// Latency: per-cycle comparisons taken 4 time units after each rising edge.
// Backpressure: the stimulus tables hold each instruction for as long as a bubble is expected.
module tb_pmips_issue_ctrl;

  // Packed output vector: {pc_stall, issue, reg_write, reg_dst, alu_src, branch,
  //                        mem_write, mem_read, mem_to_reg, alu_op[1:0]}
  localparam logic [10:0] BUB  = 11'b1_0_0000000_00;
  localparam logic [10:0] NOP  = 11'b0_1_0000000_00;
  localparam logic [10:0] ADDI = 11'b0_1_1010000_00;
  localparam logic [10:0] RTY  = 11'b0_1_1100000_10;
  localparam logic [10:0] BEQ  = 11'b0_1_0001000_01;
  localparam logic [10:0] LW   = 11'b0_1_1010011_00;
  localparam logic [10:0] SW   = 11'b0_1_0010100_00;

  typedef struct packed {
    logic [1:0]  sel;   // 0: fixed-mode DUT, 1: interlock DUT, 2: not checked
    logic        rst;
    logic [2:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [10:0] exp;
    logic [15:0] cnt;
  } row_t;

  logic        clock;
  logic        reset;
  logic [2:0]  opcode, rs, rt, rd;
  logic [2:0]  pcs, iss, rw, rdst, asrc, br, mw, mr, m2r;
  logic [1:0]  aop0, aop1, aop2;
  logic [15:0] sc0, sc1;
  logic [2:0]  sc2;
  logic [10:0] vec0, vec1;
  int          tests;
  int          failed;

  assign vec0 = {pcs[0], iss[0], rw[0], rdst[0], asrc[0], br[0], mw[0], mr[0], m2r[0], aop0};
  assign vec1 = {pcs[1], iss[1], rw[1], rdst[1], asrc[1], br[1], mw[1], mr[1], m2r[1], aop1};

  pmips_issue_ctrl #(.HAZARD_MODE(0)) u_fix (
    .clock(clock), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .pc_stall(pcs[0]), .issue(iss[0]), .reg_write(rw[0]), .reg_dst(rdst[0]),
    .alu_src(asrc[0]), .branch(br[0]), .mem_write(mw[0]), .mem_read(mr[0]),
    .mem_to_reg(m2r[0]), .alu_op(aop0), .stall_cycles(sc0)
  );

  pmips_issue_ctrl #(.HAZARD_MODE(1)) u_ilk (
    .clock(clock), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .pc_stall(pcs[1]), .issue(iss[1]), .reg_write(rw[1]), .reg_dst(rdst[1]),
    .alu_src(asrc[1]), .branch(br[1]), .mem_write(mw[1]), .mem_read(mr[1]),
    .mem_to_reg(m2r[1]), .alu_op(aop1), .stall_cycles(sc1)
  );

  pmips_issue_ctrl #(.HAZARD_MODE(0), .CNTW(3)) u_sat (
    .clock(clock), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .pc_stall(pcs[2]), .issue(iss[2]), .reg_write(rw[2]), .reg_dst(rdst[2]),
    .alu_src(asrc[2]), .branch(br[2]), .mem_write(mw[2]), .mem_read(mr[2]),
    .mem_to_reg(m2r[2]), .alu_op(aop2), .stall_cycles(sc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic row_t R(input int sel, input int rst, input int op, input int s, input int t,
                             input int d, input logic [10:0] exp, input int cnt);
    row_t r;
    r.sel = 2'(sel);
    r.rst = 1'(rst);
    r.op  = 3'(op);
    r.rs  = 3'(s);
    r.rt  = 3'(t);
    r.rd  = 3'(d);
    r.exp = exp;
    r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; opcode = 3'd3; rs = 3'd0; rt = 3'd1; rd = 3'd0;
    @(posedge clock); #4;
    tests++; if (vec0 !== BUB) begin failed++; $display("FAIL reset_hold fix: got %b want %b", vec0, BUB); end
    tests++; if (vec1 !== BUB) begin failed++; $display("FAIL reset_hold ilk: got %b want %b", vec1, BUB); end
    tests++; if (sc0 !== 16'd0) begin failed++; $display("FAIL reset_hold fix cnt: got %0d want 0", sc0); end
    tests++; if (sc1 !== 16'd0) begin failed++; $display("FAIL reset_hold ilk cnt: got %0d want 0", sc1); end
    @(posedge clock); #1; reset = 1'b0; #3;
    tests++; if (vec0 !== BUB) begin failed++; $display("FAIL reset_release fix: got %b want %b", vec0, BUB); end
    tests++; if (vec1 !== BUB) begin failed++; $display("FAIL reset_release ilk: got %b want %b", vec1, BUB); end
    @(posedge clock); #4;
    tests++; if (vec0 !== ADDI) begin failed++; $display("FAIL reset_first_issue fix: got %b want %b", vec0, ADDI); end
    tests++; if (vec1 !== ADDI) begin failed++; $display("FAIL reset_first_issue ilk: got %b want %b", vec1, ADDI); end
    tests++; if (sc0 !== 16'd0) begin failed++; $display("FAIL reset_first_issue fix cnt: got %0d want 0", sc0); end
    tests++; if (sc1 !== 16'd0) begin failed++; $display("FAIL reset_first_issue ilk cnt: got %0d want 0", sc1); end
    @(posedge clock); #1;
  endtask

  // Mode 0: every known opcode gets DEPTH=3 bubbles; unknown opcodes never stall.
  // The CNTW=3 instance sees the same bubbles and must pin at 7.
  task automatic test_fixed_stall();
    row_t q[$];
    logic [15:0] esat;
    q.push_back(R(0,1,3,0,1,0,BUB,0));  q.push_back(R(0,0,3,0,1,0,BUB,0));
    q.push_back(R(0,0,3,0,1,0,ADDI,0)); q.push_back(R(0,0,0,1,2,3,BUB,0));
    q.push_back(R(0,0,0,1,2,3,BUB,1));  q.push_back(R(0,0,0,1,2,3,BUB,2));
    q.push_back(R(0,0,0,1,2,3,RTY,3));  q.push_back(R(0,0,7,0,0,0,BUB,3));
    q.push_back(R(0,0,7,0,0,0,BUB,4));  q.push_back(R(0,0,7,0,0,0,BUB,5));
    q.push_back(R(0,0,7,0,0,0,NOP,6));  q.push_back(R(0,0,1,0,0,0,NOP,6));
    q.push_back(R(0,0,5,0,4,0,LW,6));   q.push_back(R(0,0,6,1,4,0,BUB,6));
    q.push_back(R(0,0,6,1,4,0,BUB,7));  q.push_back(R(0,0,6,1,4,0,BUB,8));
    q.push_back(R(0,0,6,1,4,0,SW,9));   q.push_back(R(0,0,2,1,2,0,BUB,9));
    q.push_back(R(0,0,2,1,2,0,BUB,10)); q.push_back(R(0,0,2,1,2,0,BUB,11));
    q.push_back(R(0,0,2,1,2,0,BEQ,12)); q.push_back(R(0,0,4,0,0,0,BUB,12));
    q.push_back(R(0,0,4,0,0,0,BUB,13)); q.push_back(R(0,0,4,0,0,0,BUB,14));
    q.push_back(R(0,0,4,0,0,0,NOP,15));
    reset = 1'b1; @(posedge clock); #1;
    foreach (q[i]) begin
      reset = q[i].rst; opcode = q[i].op; rs = q[i].rs; rt = q[i].rt; rd = q[i].rd;
      #3;
      esat = (q[i].cnt > 16'd7) ? 16'd7 : q[i].cnt;
      tests++; if (vec0 !== q[i].exp) begin failed++; $display("FAIL fixed row %0d outputs: got %b want %b", i, vec0, q[i].exp); end
      tests++; if (sc0 !== q[i].cnt) begin failed++; $display("FAIL fixed row %0d stall_cycles: got %0d want %0d", i, sc0, q[i].cnt); end
      tests++; if ({13'd0, sc2} !== esat) begin failed++; $display("FAIL saturate row %0d stall_cycles: got %0d want %0d", i, sc2, esat); end
      @(posedge clock); #1;
    end
  endtask

  // Mode 1: back-to-back issue, RAW bubbles, register-0 exemption, hazard-then-beq, sw rt hazard.
  task automatic test_interlock();
    row_t q[$];
    q.push_back(R(1,1,3,0,1,0,BUB,0));  q.push_back(R(1,0,3,0,1,0,BUB,0));
    q.push_back(R(1,0,3,0,1,0,ADDI,0)); q.push_back(R(1,0,3,2,3,0,ADDI,0));
    q.push_back(R(1,0,0,3,0,4,BUB,0));  q.push_back(R(1,0,0,3,0,4,BUB,1));
    q.push_back(R(1,0,0,3,0,4,RTY,2));  q.push_back(R(1,0,3,1,0,0,ADDI,2));
    q.push_back(R(1,0,0,0,5,2,RTY,2));  q.push_back(R(1,0,2,2,6,0,BUB,2));
    q.push_back(R(1,0,2,2,6,0,BUB,3));  q.push_back(R(1,0,2,2,6,0,BEQ,4));
    q.push_back(R(1,0,5,0,6,0,BUB,4));  q.push_back(R(1,0,5,0,6,0,BUB,5));
    q.push_back(R(1,0,5,0,6,0,BUB,6));  q.push_back(R(1,0,5,0,6,0,LW,7));
    q.push_back(R(1,0,6,0,6,0,BUB,7));  q.push_back(R(1,0,6,0,6,0,BUB,8));
    q.push_back(R(1,0,6,0,6,0,SW,9));   q.push_back(R(1,0,7,0,0,0,NOP,9));
    reset = 1'b1; @(posedge clock); #1;
    foreach (q[i]) begin
      reset = q[i].rst; opcode = q[i].op; rs = q[i].rs; rt = q[i].rt; rd = q[i].rd;
      #3;
      tests++; if (vec1 !== q[i].exp) begin failed++; $display("FAIL interlock row %0d outputs: got %b want %b", i, vec1, q[i].exp); end
      tests++; if (sc1 !== q[i].cnt) begin failed++; $display("FAIL interlock row %0d stall_cycles: got %0d want %0d", i, sc1, q[i].cnt); end
      @(posedge clock); #1;
    end
  endtask

  // Reset mid-STALL (fixed DUT) and reset right after an issue (interlock DUT): counter,
  // stall count and scoreboard must all start clean after the release bubble.
  task automatic test_reset_midway();
    row_t q[$];
    logic [10:0] act;
    logic [15:0] actc;
    q.push_back(R(0,1,3,0,1,0,BUB,0));  q.push_back(R(0,0,3,0,1,0,BUB,0));
    q.push_back(R(0,0,3,0,1,0,ADDI,0)); q.push_back(R(0,0,0,1,2,3,BUB,0));
    q.push_back(R(0,1,0,1,2,3,BUB,1));  q.push_back(R(0,0,0,1,2,3,BUB,0));
    q.push_back(R(0,0,0,1,2,3,RTY,0));  q.push_back(R(0,0,7,0,0,0,BUB,0));
    q.push_back(R(0,0,7,0,0,0,BUB,1));  q.push_back(R(0,0,7,0,0,0,BUB,2));
    q.push_back(R(0,0,7,0,0,0,NOP,3));  q.push_back(R(2,1,7,0,0,0,NOP,0));
    q.push_back(R(1,1,3,0,1,0,BUB,0));  q.push_back(R(1,0,3,0,1,0,BUB,0));
    q.push_back(R(1,1,3,0,1,0,ADDI,0)); q.push_back(R(1,0,0,1,0,2,BUB,0));
    q.push_back(R(1,0,0,1,0,2,RTY,0));  q.push_back(R(1,0,7,0,0,0,NOP,0));
    reset = 1'b1; @(posedge clock); #1;
    foreach (q[i]) begin
      reset = q[i].rst; opcode = q[i].op; rs = q[i].rs; rt = q[i].rt; rd = q[i].rd;
      #3;
      if (q[i].sel != 2'd2) begin
        act  = (q[i].sel == 2'd1) ? vec1 : vec0;
        actc = (q[i].sel == 2'd1) ? sc1 : sc0;
        tests++; if (act !== q[i].exp) begin failed++; $display("FAIL reset_mid row %0d outputs: got %b want %b", i, act, q[i].exp); end
        tests++; if (actc !== q[i].cnt) begin failed++; $display("FAIL reset_mid row %0d stall_cycles: got %0d want %0d", i, actc, q[i].cnt); end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_fixed_stall();
    test_interlock();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
